ysyx_22041461_ex_mem_reg: RTL and testbench

Pipeline boundary between the execute stage (ALU result mux, including the shift units) and the memory-access stage of the ysyx_22041461 RV64 core. It holds at most two in-flight EX results in a two-slot skid buffer with valid/ready handshakes on both sides. Its upstream ready signal comes directly from a flop, which keeps the EX-stage combinational path short. Optionally, it exposes its held results to the ID-stage bypass network.

---
 rtl/ysyx_22041461_pkg.sv | 32 +++
 rtl/ysyx_22041461_pipe_slot.sv | 42 ++++
 rtl/ysyx_22041461_ex_mem_reg.sv | 143 ++++++++++++++
 tb/tb_ysyx_22041461_ex_mem_reg.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22041461_pkg.sv
// Shared types and constants for the ysyx_22041461 EX/MEM boundary:
// datapath width, memory-op encodings, load classifier and slot-occupancy states.
package ysyx_22041461_pkg;

  localparam int XLEN = 64;
  localparam int OPW  = 4;

  localparam logic [OPW-1:0] MOP_NONE = 4'd0;
  localparam logic [OPW-1:0] MOP_LB   = 4'd1;
  localparam logic [OPW-1:0] MOP_LH   = 4'd2;
  localparam logic [OPW-1:0] MOP_LW   = 4'd3;
  localparam logic [OPW-1:0] MOP_LD   = 4'd4;
  localparam logic [OPW-1:0] MOP_LBU  = 4'd5;
  localparam logic [OPW-1:0] MOP_LHU  = 4'd6;
  localparam logic [OPW-1:0] MOP_LWU  = 4'd7;
  localparam logic [OPW-1:0] MOP_SB   = 4'd8;
  localparam logic [OPW-1:0] MOP_SH   = 4'd9;
  localparam logic [OPW-1:0] MOP_SW   = 4'd10;
  localparam logic [OPW-1:0] MOP_SD   = 4'd11;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  function automatic logic is_load(input logic [OPW-1:0] op);
    return (op == MOP_LB) || (op == MOP_LH) || (op == MOP_LW) || (op == MOP_LD) ||
           (op == MOP_LBU) || (op == MOP_LHU) || (op == MOP_LWU);
  endfunction

endpackage

// File: rtl/ysyx_22041461_pipe_slot.sv
// One payload+valid register of the EX/MEM skid buffer.
// clear wins over load; rst zeroes both valid and payload.
module ysyx_22041461_pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign q     = data_q;

endmodule

// File: rtl/ysyx_22041461_ex_mem_reg.sv
// EX/MEM two-slot skid buffer; ex_ready comes straight from the skid valid flop.
// Define YSYX_22041461_EXMEM_FWD_EN to expose both held slots to the ID bypass network.
module ysyx_22041461_ex_mem_reg
  import ysyx_22041461_pkg::*;
#(
  parameter int XLEN = ysyx_22041461_pkg::XLEN,
  parameter int OPW  = ysyx_22041461_pkg::OPW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_wen,
  input  logic [OPW-1:0]  ex_mem_op,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_pc,
  output logic [XLEN-1:0] mem_alu_out,
  output logic [XLEN-1:0] mem_store_data,
  output logic [4:0]      mem_rd,
  output logic            mem_wen,
  output logic [OPW-1:0]  mem_op
`ifdef YSYX_22041461_EXMEM_FWD_EN
  ,
  output logic            fwd0_valid,
  output logic [4:0]      fwd0_rd,
  output logic [XLEN-1:0] fwd0_data,
  output logic            fwd1_valid,
  output logic [4:0]      fwd1_rd,
  output logic [XLEN-1:0] fwd1_data
`endif
);

  localparam int PW = 3 * XLEN + 5 + 1 + OPW;

  occ_t          state_d, state_q;
  logic          ex_fire, mem_fire;
  logic          main_load, main_clear, main_sel_skid;
  logic          skid_load, skid_clear;
  logic          main_valid, skid_valid;
  logic [PW-1:0] ex_bus, main_in, main_q, skid_q;

  assign ex_bus   = {ex_pc, ex_alu_out, ex_store_data, ex_rd, ex_wen, ex_mem_op};
  assign ex_ready = ~skid_valid;
  assign ex_fire  = ex_valid & ex_ready;
  assign mem_fire = main_valid & mem_ready;
  assign main_in  = main_sel_skid ? skid_q : ex_bus;

  // Flush overrides any handshake in the same cycle; main always holds the older entry.
  always_comb begin
    state_d       = state_q;
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (ex_fire) begin
            state_d   = ONE;
            main_load = 1'b1;
          end
        end
        ONE: begin
          if (ex_fire && mem_fire) begin
            main_load = 1'b1;
          end else if (mem_fire) begin
            state_d    = EMPTY;
            main_clear = 1'b1;
          end else if (ex_fire) begin
            state_d   = TWO;
            skid_load = 1'b1;
          end
        end
        TWO: begin
          if (mem_fire) begin
            state_d       = ONE;
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  ysyx_22041461_pipe_slot #(.W(PW)) u_main (
    .clk   (clk),
    .rst   (rst),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_in),
    .valid (main_valid),
    .q     (main_q)
  );

  ysyx_22041461_pipe_slot #(.W(PW)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (ex_bus),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign mem_valid = main_valid;
  assign {mem_pc, mem_alu_out, mem_store_data, mem_rd, mem_wen, mem_op} = main_q;

`ifdef YSYX_22041461_EXMEM_FWD_EN
  logic [XLEN-1:0] skid_pc, skid_alu_out, skid_store_data;
  logic [4:0]      skid_rd;
  logic            skid_wen;
  logic [OPW-1:0]  skid_op;

  assign {skid_pc, skid_alu_out, skid_store_data, skid_rd, skid_wen, skid_op} = skid_q;

  // Loads are excluded: their alu_out is an address, not the value rd will receive.
  assign fwd0_valid = main_valid & mem_wen & (mem_rd != 5'd0) & ~is_load(mem_op);
  assign fwd0_rd    = mem_rd;
  assign fwd0_data  = mem_alu_out;
  assign fwd1_valid = skid_valid & skid_wen & (skid_rd != 5'd0) & ~is_load(skid_op);
  assign fwd1_rd    = skid_rd;
  assign fwd1_data  = skid_alu_out;
`endif

endmodule

// File: tb/tb_ysyx_22041461_ex_mem_reg.sv
// Directed self-checking bench for the EX/MEM skid buffer.
// Forwarding checks are compiled in when YSYX_22041461_EXMEM_FWD_EN is defined.
module tb_ysyx_22041461_ex_mem_reg;
  import ysyx_22041461_pkg::*;

  logic            clk = 1'b0;
  logic            rst, flush, ex_valid, ex_ready, ex_wen, mem_valid, mem_ready, mem_wen;
  logic [63:0]     ex_pc, ex_alu_out, ex_store_data, mem_pc, mem_alu_out, mem_store_data;
  logic [4:0]      ex_rd, mem_rd;
  logic [3:0]      ex_mem_op, mem_op;
`ifdef YSYX_22041461_EXMEM_FWD_EN
  logic            fwd0_valid, fwd1_valid;
  logic [4:0]      fwd0_rd, fwd1_rd;
  logic [63:0]     fwd0_data, fwd1_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_22041461_ex_mem_reg dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_pc          (ex_pc),
    .ex_alu_out     (ex_alu_out),
    .ex_store_data  (ex_store_data),
    .ex_rd          (ex_rd),
    .ex_wen         (ex_wen),
    .ex_mem_op      (ex_mem_op),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_pc         (mem_pc),
    .mem_alu_out    (mem_alu_out),
    .mem_store_data (mem_store_data),
    .mem_rd         (mem_rd),
    .mem_wen        (mem_wen),
    .mem_op         (mem_op)
`ifdef YSYX_22041461_EXMEM_FWD_EN
    ,
    .fwd0_valid     (fwd0_valid),
    .fwd0_rd        (fwd0_rd),
    .fwd0_data      (fwd0_data),
    .fwd1_valid     (fwd1_valid),
    .fwd1_rd        (fwd1_rd),
    .fwd1_data      (fwd1_data)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] alu, input logic [4:0] rd,
                               input logic wen, input logic [3:0] op);
    ex_valid   = v;
    ex_alu_out = alu;
    ex_rd      = rd;
    ex_wen     = wen;
    ex_mem_op  = op;
    ex_pc      = 64'h8000_0000 + alu;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; mem_ready = 1'b0; ex_store_data = 64'h0;
    applyStimulus(1'b1, 64'hABC, 5'd3, 1'b1, MOP_NONE);
    tick(); tick();
    checkOutput("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("rst_ex_ready", {63'd0, ex_ready}, 64'd1);
    checkOutput("rst_alu_out", mem_alu_out, 64'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
    tick();
    checkOutput("post_rst_empty", {63'd0, mem_valid}, 64'd0);

    mem_ready = 1'b1;
    applyStimulus(1'b1, 64'h100, 5'd5, 1'b1, MOP_NONE);
    tick();
    checkOutput("single_valid", {63'd0, mem_valid}, 64'd1);
    checkOutput("single_alu", mem_alu_out, 64'h100);
    checkOutput("single_rd", {59'd0, mem_rd}, 64'd5);
    checkOutput("single_pc", mem_pc, 64'h8000_0100);
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
    tick();
    checkOutput("single_drain", {63'd0, mem_valid}, 64'd0);

    // Backpressure: A and B fill both slots, C waits upstream.
    mem_ready = 1'b0;
    applyStimulus(1'b1, 64'h1, 5'd1, 1'b1, MOP_NONE);
    tick();
    checkOutput("bp_ready_after_a", {63'd0, ex_ready}, 64'd1);
    applyStimulus(1'b1, 64'h2, 5'd2, 1'b1, MOP_NONE);
    tick();
    checkOutput("bp_ready_after_b", {63'd0, ex_ready}, 64'd0);
    checkOutput("bp_head_a", mem_alu_out, 64'h1);
    applyStimulus(1'b1, 64'h3, 5'd3, 1'b1, MOP_NONE);
    tick();
    checkOutput("bp_c_held", {63'd0, ex_ready}, 64'd0);
    checkOutput("bp_head_still_a", mem_alu_out, 64'h1);
    mem_ready = 1'b1;
    tick();
    checkOutput("bp_see_b", mem_alu_out, 64'h2);
    checkOutput("bp_ready_reopen", {63'd0, ex_ready}, 64'd1);
    tick();
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
    checkOutput("bp_see_c", mem_alu_out, 64'h3);
    checkOutput("bp_c_valid", {63'd0, mem_valid}, 64'd1);
    checkOutput("bp_one_not_two", {63'd0, ex_ready}, 64'd1);
    tick();
    checkOutput("bp_no_dup", {63'd0, mem_valid}, 64'd0);

    // Flush while in TWO with a new entry presented.
    mem_ready = 1'b0;
    applyStimulus(1'b1, 64'h10, 5'd4, 1'b1, MOP_NONE);
    tick();
    applyStimulus(1'b1, 64'h11, 5'd4, 1'b1, MOP_NONE);
    tick();
    checkOutput("fl_in_two", {63'd0, ex_ready}, 64'd0);
    flush = 1'b1; mem_ready = 1'b1;
    applyStimulus(1'b1, 64'h12, 5'd4, 1'b1, MOP_NONE);
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
    checkOutput("fl_mem_valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("fl_ex_ready", {63'd0, ex_ready}, 64'd1);
    tick();
    checkOutput("fl_dropped", {63'd0, mem_valid}, 64'd0);

    // Bit-exact payload for a store carrying a sign-extended W result.
    mem_ready = 1'b0;
    ex_store_data = 64'hDEAD_BEEF;
    applyStimulus(1'b1, 64'hFFFF_FFFF_8000_0000, 5'd9, 1'b0, MOP_SD);
    tick();
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
    ex_store_data = 64'h0;
    checkOutput("w_alu", mem_alu_out, 64'hFFFF_FFFF_8000_0000);
    checkOutput("w_store", mem_store_data, 64'hDEAD_BEEF);
    checkOutput("w_pc", mem_pc, 64'h8000_0000 + 64'hFFFF_FFFF_8000_0000);
    checkOutput("w_op", {60'd0, mem_op}, {60'd0, MOP_SD});
    checkOutput("w_wen", {63'd0, mem_wen}, 64'd0);
    checkOutput("w_rd", {59'd0, mem_rd}, 64'd9);
    mem_ready = 1'b1;
    tick();
    checkOutput("w_drain", {63'd0, mem_valid}, 64'd0);

`ifdef YSYX_22041461_EXMEM_FWD_EN
    mem_ready = 1'b0;
    applyStimulus(1'b1, 64'h55, 5'd0, 1'b1, MOP_NONE);
    tick();
    checkOutput("fwd_rd0", {63'd0, fwd0_valid}, 64'd0);
    mem_ready = 1'b1;
    applyStimulus(1'b1, 64'h66, 5'd3, 1'b1, MOP_LD);
    tick();
    checkOutput("fwd_load", {63'd0, fwd0_valid}, 64'd0);
    applyStimulus(1'b1, 64'h77, 5'd7, 1'b1, MOP_NONE);
    tick();
    checkOutput("fwd0_valid", {63'd0, fwd0_valid}, 64'd1);
    checkOutput("fwd0_data", fwd0_data, 64'h77);
    checkOutput("fwd0_rd", {59'd0, fwd0_rd}, 64'd7);
    mem_ready = 1'b0;
    applyStimulus(1'b1, 64'h99, 5'd9, 1'b1, MOP_NONE);
    tick();
    checkOutput("fwd1_valid", {63'd0, fwd1_valid}, 64'd1);
    checkOutput("fwd1_data", fwd1_data, 64'h99);
    checkOutput("fwd1_rd", {59'd0, fwd1_rd}, 64'd9);
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
`else
    // Fill both slots so the reset below lands mid-stall.
    mem_ready = 1'b0;
    applyStimulus(1'b1, 64'h77, 5'd7, 1'b1, MOP_NONE);
    tick();
    applyStimulus(1'b1, 64'h99, 5'd9, 1'b1, MOP_NONE);
    tick();
    applyStimulus(1'b0, 64'h0, 5'd0, 1'b0, MOP_NONE);
`endif

    checkOutput("stall_before_rst", {63'd0, ex_ready}, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst2_mem_valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("rst2_ex_ready", {63'd0, ex_ready}, 64'd1);
    checkOutput("rst2_alu", mem_alu_out, 64'd0);
    checkOutput("rst2_pc", mem_pc, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
